// File: rtl/ll_sc_monitor.sv
// LL/SC reservation monitor: tracks one linked word address for the MEM stage,
// kills it on flush, SC, matching external write or timeout, and grades each SC.
//
// Ports:
//   clk, rst (async, active-low)
//   flush                 - exception/ERET flush, kills the link and any same-cycle SC
//   ll_req, ll_addr       - LL in MEM this cycle and its effective address
//   sc_req, sc_addr       - SC in MEM this cycle and its effective address
//   snoop_we, snoop_addr  - committed write from another master
//   LLbit_o               - 1 while a link is held
//   link_addr_o           - linked word address (bits [1:0] = 0)
//   sc_store_en           - combinational write gate for the SC store
//   sc_done, sc_success   - registered SC completion pulse and result

module ll_sc_monitor #(
    parameter int ADDR_W       = 32,
    parameter int LINK_TIMEOUT = 1024,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ll_req,
    input  logic [ADDR_W-1:0] ll_addr,
    input  logic              sc_req,
    input  logic [ADDR_W-1:0] sc_addr,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              LLbit_o,
    output logic [ADDR_W-1:0] link_addr_o,
    output logic              sc_store_en,
    output logic              sc_done,
    output logic              sc_success
);

    typedef enum logic {
        IDLE   = 1'b0,
        LINKED = 1'b1
    } state_t;

    localparam bit TO_EN = (LINK_TIMEOUT > 0);

    // Last counter value of a link's life; unused when the timeout is disabled.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((LINK_TIMEOUT > 0) ? LINK_TIMEOUT - 1 : 0);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] link_addr;

    logic sc_match;
    logic snoop_hit;
    logic sc_ok;
    logic cnt_expired;

    // Word granularity: byte offset bits never take part in a match.
    assign sc_match  = (sc_addr[ADDR_W-1:2] == link_addr[ADDR_W-1:2]);

    assign snoop_hit = snoop_we &&
                       (snoop_addr[ADDR_W-1:2] == link_addr[ADDR_W-1:2]);

    // A same-cycle external write to the linked word beats the SC.
    assign sc_ok = rst &&
                   !flush &&
                   sc_req &&
                   (state == LINKED) &&
                   sc_match &&
                   !snoop_hit;

    assign sc_store_en = sc_ok;

    assign cnt_expired = TO_EN && (cnt == CNT_LAST);

    assign LLbit_o     = (state == LINKED);
    assign link_addr_o = link_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            link_addr  <= '0;
            sc_done    <= 1'b0;
            sc_success <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            sc_done    <= 1'b0;
            sc_success <= 1'b0;
        end else if (sc_req) begin
            // Every SC consumes the link, whatever its outcome.
            state      <= IDLE;
            cnt        <= '0;
            sc_done    <= 1'b1;
            sc_success <= sc_ok;
        end else begin
            sc_done    <= 1'b0;
            sc_success <= 1'b0;
            if (ll_req) begin
                // LL wins over a same-cycle snoop and re-links from any state.
                state     <= LINKED;
                cnt       <= '0;
                link_addr <= {ll_addr[ADDR_W-1:2], 2'b00};
            end else if (state == LINKED) begin
                if (snoop_hit) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt_expired) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (TO_EN) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

    // Byte offsets are architecturally irrelevant to the reservation.
    logic unused_lsbs;
    assign unused_lsbs = ^{ll_addr[1:0], sc_addr[1:0], snoop_addr[1:0]};

endmodule

// File: tb/tb_ll_sc_monitor.sv
// Self-checking bench for ll_sc_monitor: directed scenarios followed by
// randomized traffic against a reservation model tracking link age in cycles.

module tb_ll_sc_monitor;

    localparam int AW = 32;
    localparam int TO = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          ll_req;
    logic [AW-1:0] ll_addr;
    logic          sc_req;
    logic [AW-1:0] sc_addr;
    logic          snoop_we;
    logic [AW-1:0] snoop_addr;
    logic          LLbit_o;
    logic [AW-1:0] link_addr_o;
    logic          sc_store_en;
    logic          sc_done;
    logic          sc_success;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a reservation is a word address plus its age in cycles.
    bit          m_linked;
    logic [31:0] m_laddr;
    int          m_age;
    bit          m_done;
    bit          m_succ;
    logic        se_seen;

    ll_sc_monitor #(
        .ADDR_W      (AW),
        .LINK_TIMEOUT(TO),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .ll_req     (ll_req),
        .ll_addr    (ll_addr),
        .sc_req     (sc_req),
        .sc_addr    (sc_addr),
        .snoop_we   (snoop_we),
        .snoop_addr (snoop_addr),
        .LLbit_o    (LLbit_o),
        .link_addr_o(link_addr_o),
        .sc_store_en(sc_store_en),
        .sc_done    (sc_done),
        .sc_success (sc_success)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit same_word(input logic [31:0] a,
                                     input logic [31:0] b);
        return (a >> 2) == (b >> 2);
    endfunction

    function automatic bit model_sc_ok();
        return rst && !flush && sc_req && m_linked &&
               same_word(sc_addr, m_laddr) &&
               !(snoop_we && same_word(snoop_addr, m_laddr));
    endfunction

    task automatic model_reset();
        m_linked = 0;
        m_laddr  = '0;
        m_age    = 0;
        m_done   = 0;
        m_succ   = 0;
    endtask

    task automatic model_edge();
        bit ok;
        ok = model_sc_ok();
        if (flush) begin
            m_linked = 0;
            m_done   = 0;
            m_succ   = 0;
        end else if (sc_req) begin
            m_linked = 0;
            m_done   = 1;
            m_succ   = ok;
        end else begin
            m_done = 0;
            m_succ = 0;
            if (ll_req) begin
                m_linked = 1;
                m_laddr  = ll_addr & 32'hFFFF_FFFC;
                m_age    = 1;
            end else if (m_linked) begin
                if (snoop_we && same_word(snoop_addr, m_laddr)) begin
                    m_linked = 0;
                end else begin
                    m_age++;
                    if (m_age > TO) m_linked = 0;
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("LLbit_o",     {31'b0, LLbit_o},    {31'b0, m_linked});
        chk("link_addr_o", link_addr_o,         m_laddr);
        chk("sc_done",     {31'b0, sc_done},    {31'b0, m_done});
        chk("sc_success",  {31'b0, sc_success}, {31'b0, m_succ});
    endtask

    task automatic step(input logic f,
                        input logic ll, input logic [31:0] la,
                        input logic sc, input logic [31:0] sa,
                        input logic sw, input logic [31:0] wa);
        @(negedge clk);
        flush      = f;
        ll_req     = ll;
        ll_addr    = la;
        sc_req     = sc;
        sc_addr    = sa;
        snoop_we   = sw;
        snoop_addr = wa;
        #2;
        se_seen = sc_store_en;
        chk("sc_store_en", {31'b0, sc_store_en}, {31'b0, model_sc_ok()});
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_ll(input logic [31:0] a);
        step(0, 1, a, 0, 0, 0, 0);
    endtask

    task automatic do_sc(input logic [31:0] a);
        step(0, 0, 0, 1, a, 0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h100;
            1:       base = 32'h104;
            default: base = 32'h200;
        endcase
        return base + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        flush = 0; ll_req = 0; sc_req = 0; snoop_we = 0;
        ll_addr = 0; sc_addr = 0; snoop_addr = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        model_reset();
        check_regs();
        chk("rst_store_en", {31'b0, sc_store_en}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // LL then SC three cycles later succeeds.
        do_ll(32'h1000);
        idle();
        idle();
        do_sc(32'h1000);
        chk("d1_se",   {31'b0, se_seen},    32'h1);
        chk("d1_succ", {31'b0, sc_success}, 32'h1);
        chk("d1_done", {31'b0, sc_done},    32'h1);
        chk("d1_ll",   {31'b0, LLbit_o},    32'h0);

        // Snoop to another byte of the linked word kills the link.
        do_ll(32'h1000);
        step(0, 0, 0, 0, 0, 1, 32'h1002);
        chk("d2_ll",   {31'b0, LLbit_o},    32'h0);
        do_sc(32'h1000);
        chk("d2_se",   {31'b0, se_seen},    32'h0);
        chk("d2_done", {31'b0, sc_done},    32'h1);
        chk("d2_succ", {31'b0, sc_success}, 32'h0);

        // Timeout: link lasts exactly TO cycles.
        do_ll(32'h20);
        for (int i = 0; i < TO - 1; i++) begin
            chk("d3_hold", {31'b0, LLbit_o}, 32'h1);
            idle();
        end
        chk("d3_last", {31'b0, LLbit_o}, 32'h1);
        idle();
        chk("d3_drop", {31'b0, LLbit_o}, 32'h0);
        do_sc(32'h20);
        chk("d3_late", {31'b0, sc_success}, 32'h0);
        do_ll(32'h20);
        for (int i = 0; i < TO - 1; i++) idle();
        do_sc(32'h20);
        chk("d3_edge", {31'b0, sc_success}, 32'h1);

        // Flush swallows a same-cycle SC.
        do_ll(32'h40);
        step(1, 0, 0, 1, 32'h40, 0, 0);
        chk("d4_se",   {31'b0, se_seen}, 32'h0);
        chk("d4_done", {31'b0, sc_done}, 32'h0);
        chk("d4_ll",   {31'b0, LLbit_o}, 32'h0);

        // Address mismatch fails; re-LL moves the reservation.
        do_ll(32'h40);
        do_sc(32'h80);
        chk("d5_miss", {31'b0, sc_success}, 32'h0);
        do_ll(32'h40);
        do_ll(32'h83);
        chk("d5_addr", link_addr_o, 32'h80);
        do_sc(32'h80);
        chk("d5_succ", {31'b0, sc_success}, 32'h1);

        // Same-cycle LL and matching snoop: LL wins.
        step(0, 1, 32'h300, 0, 0, 1, 32'h300);
        chk("d6_ll", {31'b0, LLbit_o}, 32'h1);
        // SC and LL together: SC handled, LL ignored.
        step(0, 1, 32'h400, 1, 32'h300, 0, 0);
        chk("d6_succ", {31'b0, sc_success}, 32'h1);
        chk("d6_ll2",  {31'b0, LLbit_o},    32'h0);

        // Async reset between LL and SC.
        do_ll(32'h1000);
        @(negedge clk);
        flush = 0; ll_req = 0; snoop_we = 0;
        sc_req = 1; sc_addr = 32'h1000;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs();
        chk("d7_se", {31'b0, sc_store_en}, 32'h0);
        sc_req = 0;
        #1 rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_regs();
        do_sc(32'h1000);
        chk("d7_succ", {31'b0, sc_success}, 32'h0);
        chk("d7_done", {31'b0, sc_done},    32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 15) == 0,
                 $urandom_range(0, 4) == 0, rand_addr(),
                 $urandom_range(0, 4) == 0, rand_addr(),
                 $urandom_range(0, 3) == 0, rand_addr());
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ll_sc_monitor.md
LL_SC_MONITOR -- requirements
Module: ll_sc_monitor

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter LINK_TIMEOUT, default 1024, the number of cycles a link may stay LINKED; 0 disables the timeout.
REQ-003 SHALL have parameter CNT_W, default 16, timeout counter width; LINK_TIMEOUT SHALL be < 2^CNT_W.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  exception/ERET flush; kills the link.
REQ-007 ll_req  in  1  LL executing in the MEM stage this cycle.
REQ-008 ll_addr  in  ADDR_W  LL effective address.
REQ-009 sc_req  in  1  SC executing in the MEM stage this cycle.
REQ-010 sc_addr  in  ADDR_W  SC effective address.
REQ-011 snoop_we  in  1  a write by another master (DMA or bus) is committed this cycle.
REQ-012 snoop_addr  in  ADDR_W  address of that external write.
REQ-013 LLbit_o  out  1  1 while state is LINKED.
REQ-014 link_addr_o  out  ADDR_W  linked address, word-aligned with bits [1:0] = 0.
REQ-015 sc_store_en  out  1  combinational; 1 when sc_req is high and the SC will succeed this cycle, gating the data-memory write.
REQ-016 sc_done  out  1  registered one-cycle pulse, one cycle after sc_req.
REQ-017 sc_success  out  1  registered SC result (1 = success, 0 = fail); meaningful while sc_done is high, 0 otherwise.

Function
REQ-018 SHALL implement two states: IDLE (LLbit_o=0) and LINKED (LLbit_o=1).
REQ-019 Address match SHALL compare bits [ADDR_W-1:2] only, i.e. word granularity.
REQ-020 Per-cycle event priority SHALL be: rst > flush > sc_req > ll_req > snoop/timeout.
REQ-021 flush SHALL force the next state to IDLE and the counter to 0; sc_store_en=0, sc_done=0 and sc_success=0 that cycle, even if sc_req is high.
REQ-022 On ll_req without flush or sc_req, the block SHALL:
- enter LINKED
- capture ll_addr word-aligned into link_addr_o
- clear the counter
This applies from either state; a re-LL overwrites the address.
REQ-023 If snoop_we matches ll_addr in the same cycle as ll_req, the LL SHALL win and the link SHALL be established.
REQ-024 sc_store_en SHALL be 1 only when sc_req=1, flush=0, state=LINKED, sc_addr matches link_addr_o, and no same-cycle snoop_we matches link_addr_o.
REQ-025 On sc_req, next-cycle sc_done SHALL be 1 and sc_success SHALL equal the same-cycle sc_store_en.
REQ-026 Every SC, pass or fail, SHALL leave the next state IDLE.
REQ-027 If sc_req and ll_req are both high in one cycle, the SC SHALL be processed and the LL ignored.
REQ-028 In LINKED, snoop_we matching link_addr_o SHALL move the block to IDLE next cycle.
REQ-029 A non-matching snoop SHALL have no effect.
REQ-030 In LINKED with LINK_TIMEOUT>0, the counter SHALL increment every cycle with no higher-priority event.
REQ-031 When the counter equals LINK_TIMEOUT-1, the block SHALL move to IDLE next cycle, so LLbit_o stays high exactly LINK_TIMEOUT cycles after the LL edge.
REQ-032 In IDLE the counter SHALL hold at 0; it SHALL never wrap.
REQ-033 link_addr_o SHALL hold its value in IDLE and change only on an accepted LL.
REQ-034 sc_done and sc_success SHALL be 0 in every cycle not following an unflushed sc_req.

Reset
REQ-035 rst low SHALL immediately, without a clock, force:
- state IDLE, LLbit_o=0
- link_addr_o=0
- counter=0
- sc_done=0, sc_success=0
REQ-036 sc_store_en SHALL be 0 while rst is low.
REQ-037 rst asserted mid-link or mid-SC SHALL drop the pending result.
REQ-038 The first event SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-039 ll_req @0x1000, then sc_req @0x1000 three cycles later -> sc_store_en=1 that cycle; next cycle sc_done=1, sc_success=1, LLbit_o=0.
REQ-040 ll_req @0x1000, then snoop_we @0x1002, then sc_req @0x1000 -> snoop clears LLbit_o; sc_store_en=0; sc_success=0 with sc_done=1.
REQ-041 LINK_TIMEOUT=4: ll_req @0x20, idle -> LLbit_o high exactly 4 cycles; sc_req on cycle 5 fails; sc_req on cycle 4 succeeds.
REQ-042 ll_req @0x40, then sc_req @0x40 with flush in the same cycle -> sc_store_en=0, no sc_done pulse, LLbit_o=0.
REQ-043 ll_req @0x40, then sc_req @0x80 -> fail (sc_success=0); ll_req @0x40 followed by ll_req @0x80, then sc_req @0x80 -> success; link_addr_o=0x80.
REQ-044 rst pulsed low between the LL and SC edges -> outputs zero asynchronously; following SC fails.
